// File: rtl/score_pkg.sv
// Shared types, default coefficients and helpers for the weighted score engine.
package score_pkg;

   // Engine control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Reset-time coefficients (already multiplied by the score scale of 100).
   localparam int DEF_COEF_0 = 35;
   localparam int DEF_COEF_1 = 30;
   localparam int DEF_COEF_2 = 20;
   localparam int DEF_COEF_3 = 15;

   // Default coefficient for channel i; channels beyond the fourth start at zero.
   function automatic int default_coef(input int i);
      case (i)
         0:       return DEF_COEF_0;
         1:       return DEF_COEF_1;
         2:       return DEF_COEF_2;
         3:       return DEF_COEF_3;
         default: return 0;
      endcase
   endfunction

   // Width of a channel index; a single-channel build still carries one index bit.
   function automatic int idx_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/weighted_score_engine_if.sv
// Handshake, coefficient-write and result bundle of the weighted score engine.
interface weighted_score_engine_if
   import score_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IN_W   = 16,
   parameter int COEF_W = 8,
   parameter int OUT_W  = 32
) ();

   localparam int IDX_W = idx_width(NUM_CH);

   // Input vector handshake
   logic                   in_valid;
   logic                   in_ready;
   logic [NUM_CH*IN_W-1:0] in_data;

   // Coefficient write port
   logic                   coef_wr_en;
   logic [IDX_W-1:0]       coef_wr_idx;
   logic [COEF_W-1:0]      coef_wr_data;
   logic                   coef_err;

   // Result handshake
   logic                   out_valid;
   logic                   out_ready;
   logic [OUT_W-1:0]       score;
   logic                   overflow;

   // Engine side
   modport slave (
      input  in_valid, in_data, coef_wr_en, coef_wr_idx, coef_wr_data, out_ready,
      output in_ready, coef_err, out_valid, score, overflow
   );

   // Producer / consumer side
   modport master (
      output in_valid, in_data, coef_wr_en, coef_wr_idx, coef_wr_data, out_ready,
      input  in_ready, coef_err, out_valid, score, overflow
   );

endinterface

// File: rtl/score_coef_regs.sv
// Coefficient register file: writable copy plus a per-transaction snapshot that
// the multiplier reads, so a write landing on the accept edge cannot leak into
// the transaction being accepted.
module score_coef_regs
   import score_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int COEF_W = 8,
   parameter int IDX_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [COEF_W-1:0] wr_data,
   input  logic              wr_allow,
   input  logic              snap,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [COEF_W-1:0] rd_data,
   output logic              coef_err
);

   // Channel count in an index-plus-one width so the range check has matching widths.
   localparam logic [IDX_W:0] NUM_CH_V = (IDX_W + 1)'(NUM_CH);

   logic [COEF_W-1:0] coef_reg [NUM_CH];
   logic [COEF_W-1:0] act_reg  [NUM_CH];
   logic              coef_err_reg;
   logic              idx_ok;
   logic              wr_ok;

   assign idx_ok = ({1'b0, wr_idx} < NUM_CH_V);
   assign wr_ok  = wr_en && wr_allow && idx_ok;

   // Writable coefficients: defaults on reset, single-entry update on an accepted write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++)
            coef_reg[i] <= COEF_W'(default_coef(i));
      end else if (wr_ok) begin
         for (int i = 0; i < NUM_CH; i++)
            if (wr_idx == IDX_W'(i))
               coef_reg[i] <= wr_data;
      end
   end

   // Snapshot taken on the accept edge holds the pre-write coefficients for the whole pass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++)
            act_reg[i] <= COEF_W'(default_coef(i));
      end else if (snap) begin
         for (int i = 0; i < NUM_CH; i++)
            act_reg[i] <= coef_reg[i];
      end
   end

   // One-cycle error pulse for a write outside IDLE or aimed past the last channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         coef_err_reg <= 1'b0;
      else
         coef_err_reg <= wr_en && !(wr_allow && idx_ok);
   end

   // Asynchronous read of the snapshot for the channel currently being multiplied.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (rd_idx == IDX_W'(i))
            rd_data = act_reg[i];
   end

   assign coef_err = coef_err_reg;

endmodule

// File: rtl/weighted_score_engine.sv
// Weighted-sum scorer: one shared multiplier walks the channels, accumulates
// coefficient*sample products and returns a saturated score over valid/ready.
module weighted_score_engine
   import score_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IN_W   = 16,
   parameter int COEF_W = 8,
   parameter int OUT_W  = 32,
   parameter int SCALE  = 100
) (
   input  logic                    clk,
   input  logic                    rst,
   weighted_score_engine_if.slave  bus
);

   localparam int IDX_W  = idx_width(NUM_CH);
   localparam int PROD_W = IN_W + COEF_W;
   // One spare bit above the sum of NUM_CH products, so the accumulator never wraps.
   localparam int ACC_W  = IN_W + COEF_W + $clog2(NUM_CH) + 1;

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [ACC_W-1:0]  acc_reg, acc_next;
   logic [OUT_W-1:0]  score_reg, score_next;
   logic              overflow_reg, overflow_next;
   logic [IN_W-1:0]   sample_reg [NUM_CH];
   logic [IN_W-1:0]   in_ch      [NUM_CH];

   logic              accept;
   logic              last_ch;
   logic [IN_W-1:0]   sel_sample;
   logic [COEF_W-1:0] sel_coef;
   logic [PROD_W-1:0] prod;
   logic [ACC_W-1:0]  acc_sum;
   logic [OUT_W-1:0]  sat_score;
   logic              sat_ovf;

   // Split the packed input bus into per-channel samples.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_in_ch
         assign in_ch[gi] = bus.in_data[gi*IN_W +: IN_W];
      end
   endgenerate

   score_coef_regs #(
      .NUM_CH (NUM_CH),
      .COEF_W (COEF_W),
      .IDX_W  (IDX_W)
   ) u_coef (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (bus.coef_wr_en),
      .wr_idx   (bus.coef_wr_idx),
      .wr_data  (bus.coef_wr_data),
      .wr_allow (state_reg == IDLE),
      .snap     (accept),
      .rd_idx   (idx_reg),
      .rd_data  (sel_coef),
      .coef_err (bus.coef_err)
   );

   // Pick the sample for the channel the multiplier is working on.
   always_comb begin
      sel_sample = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (idx_reg == IDX_W'(i))
            sel_sample = sample_reg[i];
   end

   assign prod    = PROD_W'(sel_coef) * PROD_W'(sel_sample);
   assign acc_sum = acc_reg + ACC_W'(prod);
   assign last_ch = (idx_reg == IDX_W'(NUM_CH - 1));

   // Clamp to the score width; when the score is wide enough nothing can saturate.
   generate
      if (OUT_W >= ACC_W) begin : g_nosat
         assign sat_score = OUT_W'(acc_sum);
         assign sat_ovf   = 1'b0;
      end else begin : g_sat
         assign sat_ovf   = |acc_sum[ACC_W-1:OUT_W];
         assign sat_score = sat_ovf ? {OUT_W{1'b1}} : acc_sum[OUT_W-1:0];
      end
   endgenerate

   // Next-state, index, accumulator and result selection.
   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      acc_next      = acc_reg;
      score_next    = score_reg;
      overflow_next = overflow_reg;
      accept        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               accept     = 1'b1;
               idx_next   = '0;
               acc_next   = '0;
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            acc_next = acc_sum;
            if (last_ch) begin
               idx_next      = '0;
               score_next    = sat_score;
               overflow_next = sat_ovf;
               state_next    = DONE;
            end else begin
               idx_next = idx_reg + IDX_W'(1);
            end
         end
         DONE: begin
            if (bus.out_ready)
               state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Control and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         idx_reg      <= '0;
         acc_reg      <= '0;
         score_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         acc_reg      <= acc_next;
         score_reg    <= score_next;
         overflow_reg <= overflow_next;
      end
   end

   // Capture the input vector only on the accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++)
            sample_reg[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < NUM_CH; i++)
            sample_reg[i] <= in_ch[i];
      end
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.score     = score_reg;
   assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_weighted_score_engine.sv
// Directed bench for the weighted score engine: default build, a 20-bit score
// build for saturation and a single-channel build.
module tb_weighted_score_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   localparam logic [63:0] DEF_VEC = {16'd45, 16'd4096, 16'd200, 16'd1000};
   localparam logic [63:0] MAX_VEC = {4{16'hFFFF}};

   always #5 clk = ~clk;

   weighted_score_engine_if #(.NUM_CH(4), .IN_W(16), .COEF_W(8), .OUT_W(32)) ifa ();
   weighted_score_engine_if #(.NUM_CH(4), .IN_W(16), .COEF_W(8), .OUT_W(20)) ifs ();
   weighted_score_engine_if #(.NUM_CH(1), .IN_W(16), .COEF_W(8), .OUT_W(32)) ifo ();

   weighted_score_engine #(.NUM_CH(4), .IN_W(16), .COEF_W(8), .OUT_W(32)) dut_a (
      .clk (clk), .rst (rst), .bus (ifa.slave));
   weighted_score_engine #(.NUM_CH(4), .IN_W(16), .COEF_W(8), .OUT_W(20)) dut_s (
      .clk (clk), .rst (rst), .bus (ifs.slave));
   weighted_score_engine #(.NUM_CH(1), .IN_W(16), .COEF_W(8), .OUT_W(32)) dut_o (
      .clk (clk), .rst (rst), .bus (ifo.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Observation helpers, d selects the build: 0 default, 1 narrow score, 2 single channel.
   function automatic logic [31:0] score_of(input int d);
      case (d)
         0:       return ifa.score;
         1:       return 32'(ifs.score);
         default: return ifo.score;
      endcase
   endfunction

   function automatic logic valid_of(input int d);
      case (d)
         0:       return ifa.out_valid;
         1:       return ifs.out_valid;
         default: return ifo.out_valid;
      endcase
   endfunction

   function automatic logic ready_of(input int d);
      case (d)
         0:       return ifa.in_ready;
         1:       return ifs.in_ready;
         default: return ifo.in_ready;
      endcase
   endfunction

   function automatic logic ovf_of(input int d);
      case (d)
         0:       return ifa.overflow;
         1:       return ifs.overflow;
         default: return ifo.overflow;
      endcase
   endfunction

   function automatic logic cerr_of(input int d);
      case (d)
         0:       return ifa.coef_err;
         1:       return ifs.coef_err;
         default: return ifo.coef_err;
      endcase
   endfunction

   task automatic drive_in(input int d, input logic v, input logic [63:0] data);
      case (d)
         0:       begin ifa.in_valid = v; ifa.in_data = data;        end
         1:       begin ifs.in_valid = v; ifs.in_data = data;        end
         default: begin ifo.in_valid = v; ifo.in_data = data[15:0];  end
      endcase
   endtask

   task automatic drive_wr(input int d, input logic en, input int idx, input int val);
      case (d)
         0:       begin ifa.coef_wr_en = en; ifa.coef_wr_idx = 2'(idx); ifa.coef_wr_data = 8'(val); end
         1:       begin ifs.coef_wr_en = en; ifs.coef_wr_idx = 2'(idx); ifs.coef_wr_data = 8'(val); end
         default: begin ifo.coef_wr_en = en; ifo.coef_wr_idx = 1'(idx); ifo.coef_wr_data = 8'(val); end
      endcase
   endtask

   // Present a vector for exactly one accept edge, then scramble the bus.
   task automatic start(input int d, input logic [63:0] data);
      drive_in(d, 1'b1, data);
      tick();
      drive_in(d, 1'b0, {$urandom, $urandom});
   endtask

   // Wait (bounded) for out_valid and check latency and result.
   task automatic await(input int d, input string tag, input int lat,
                        input logic [31:0] exp, input logic eovf);
      int n;
      n = 0;
      while (!valid_of(d) && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_score"}, 64'(score_of(d)), 64'(exp));
      check({tag, "_overflow"}, 64'(ovf_of(d)), 64'(eovf));
      check({tag, "_in_ready_low"}, 64'(ready_of(d)), 64'd0);
   endtask

   // Complete the output handshake with out_ready already high.
   task automatic release_out(input int d, input string tag, input logic [31:0] exp);
      tick();
      check({tag, "_valid_drop"}, 64'(valid_of(d)), 64'd0);
      check({tag, "_ready_back"}, 64'(ready_of(d)), 64'd1);
      check({tag, "_score_held"}, 64'(score_of(d)), 64'(exp));
   endtask

   task automatic run(input int d, input string tag, input logic [63:0] data,
                      input int lat, input logic [31:0] exp, input logic eovf);
      start(d, data);
      await(d, tag, lat, exp, eovf);
      $display("txn %s: score=%0d overflow=%0b", tag, score_of(d), ovf_of(d));
      release_out(d, tag, exp);
   endtask

   task automatic write(input int d, input int idx, input int val, input logic eerr);
      drive_wr(d, 1'b1, idx, val);
      tick();
      drive_wr(d, 1'b0, 0, 0);
      check("coef_write_err", 64'(cerr_of(d)), 64'(eerr));
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         drive_in(d, 1'b0, 64'd0);
         drive_wr(d, 1'b0, 0, 0);
      end
      ifa.out_ready = 1'b1;
      ifs.out_ready = 1'b1;
      ifo.out_ready = 1'b1;

      // Reset state while rst is held
      tick();
      tick();
      check("rst_in_ready", 64'(ifa.in_ready), 64'd1);
      check("rst_out_valid", 64'(ifa.out_valid), 64'd0);
      check("rst_score", 64'(ifa.score), 64'd0);
      check("rst_overflow", 64'(ifa.overflow), 64'd0);
      check("rst_coef_err", 64'(ifa.coef_err), 64'd0);
      rst = 1'b0;
      tick();

      // Default coefficients: 1000*35 + 200*30 + 4096*20 + 45*15
      run(0, "defaults", DEF_VEC, 4, 32'd123595, 1'b0);

      // Backpressure: result held, new vectors refused
      ifa.out_ready = 1'b0;
      start(0, DEF_VEC);
      await(0, "bp", 4, 32'd123595, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive_in(0, 1'b1, MAX_VEC);
         tick();
         check("bp_valid_hold", 64'(ifa.out_valid), 64'd1);
         check("bp_score_hold", 64'(ifa.score), 64'd123595);
         check("bp_in_ready", 64'(ifa.in_ready), 64'd0);
      end
      drive_in(0, 1'b0, 64'd0);
      ifa.out_ready = 1'b1;
      release_out(0, "bp", 32'd123595);

      // Coefficient write in IDLE: channel 2 weight to 0
      write(0, 2, 0, 1'b0);
      run(0, "coef2_zero", DEF_VEC, 4, 32'd41675, 1'b0);

      // Write during ACCUM is rejected with a single-cycle error pulse
      start(0, DEF_VEC);
      drive_wr(0, 1'b1, 2, 99);
      tick();
      drive_wr(0, 1'b0, 0, 0);
      check("accum_wr_err_pulse", 64'(ifa.coef_err), 64'd1);
      tick();
      check("accum_wr_err_clear", 64'(ifa.coef_err), 64'd0);
      await(0, "accum_wr", 2, 32'd41675, 1'b0);
      release_out(0, "accum_wr", 32'd41675);

      // Write on the accept edge: applied, but this transaction sees the old weight
      drive_in(0, 1'b1, DEF_VEC);
      drive_wr(0, 1'b1, 2, 20);
      tick();
      drive_in(0, 1'b0, 64'd0);
      drive_wr(0, 1'b0, 0, 0);
      check("same_edge_err", 64'(ifa.coef_err), 64'd0);
      await(0, "same_edge", 4, 32'd41675, 1'b0);
      release_out(0, "same_edge", 32'd41675);
      run(0, "after_same_edge", DEF_VEC, 4, 32'd123595, 1'b0);

      // Reset mid-ACCUM discards the pass and restores default weights
      write(0, 2, 0, 1'b0);
      start(0, DEF_VEC);
      tick();
      #3 rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(ifa.out_valid), 64'd0);
      check("midrst_score", 64'(ifa.score), 64'd0);
      check("midrst_in_ready", 64'(ifa.in_ready), 64'd1);
      tick();
      rst = 1'b0;
      tick();
      run(0, "post_reset", DEF_VEC, 4, 32'd123595, 1'b0);

      // Narrow score build: fits without saturation, then saturates
      run(1, "narrow_def", DEF_VEC, 4, 32'd123595, 1'b0);
      for (int i = 0; i < 4; i++)
         write(1, i, 255, 1'b0);
      run(1, "saturate", MAX_VEC, 4, 32'd1048575, 1'b1);

      // Single-channel build
      run(2, "one_ch", 64'd7, 1, 32'd245, 1'b0);
      write(2, 1, 50, 1'b1);
      tick();
      check("one_ch_err_clear", 64'(ifo.coef_err), 64'd0);
      run(2, "one_ch_unchanged", 64'd7, 1, 32'd245, 1'b0);
      write(2, 0, 2, 1'b0);
      run(2, "one_ch_rewritten", 64'd7, 1, 32'd14, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/weighted_score_engine.md
# weighted_score_engine

Parametrised weighted-sum benchmark scorer, successor to the fixed four-term scorer. It accepts a vector of NUM_CH unsigned telemetry channels and multiplies each by a runtime-writable coefficient. One shared multiplier accumulates the products over NUM_CH cycles, and the engine returns a saturated score through a valid/ready handshake. It sits between the telemetry sampling stage and the UART report formatter.

## Interface
- NUM_CH, 4: number of input channels, ≥1.
- IN_W, 16: width of each channel sample.
- COEF_W, 8: coefficient width, unsigned, pre-multiplied by SCALE.
- OUT_W, 32: score width.
- SCALE, 100: coefficient scale factor, documentation only. The score equals SCALE × the true score.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  an input vector is presented.
- in_ready  out  1  the engine can accept a vector. It is high only in IDLE.
- in_data  in  NUM_CH*IN_W  channel i occupies bits [i*IN_W +: IN_W].
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_idx  in  IDX_W  channel index to write. IDX_W = max(1, $clog2(NUM_CH)).
- coef_wr_data  in  COEF_W  new coefficient value.
- coef_err  out  1  one-cycle pulse when a write is rejected.
- out_valid  out  1  score and overflow are valid.
- out_ready  in  1  the consumer accepts the result.
- score  out  OUT_W  saturated weighted sum.
- overflow  out  1  set when the score was saturated. Qualified by out_valid.

## Operation
- FSM states are IDLE, ACCUM and DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_data into the sample register;
  - clear the accumulator and the overflow accumulator;
  - set idx=0 and go to ACCUM.
- ACCUM: each cycle, add coef[idx]*sample[idx] to the accumulator and increment idx.
  - The product width is IN_W+COEF_W.
  - The accumulator width is IN_W+COEF_W+$clog2(NUM_CH)+1, so the accumulator itself never wraps.
  - On the cycle with idx==NUM_CH-1, register score = min(acc_next, 2^OUT_W-1) and overflow = (acc_next > 2^OUT_W-1), then go to DONE.
- DONE: out_valid=1. score and overflow are held stable until out_valid&&out_ready, then the FSM goes to IDLE.
  - score keeps its last value after the handshake. out_valid drops.
- Coefficient register file:
  - reset values are coef[0..3] = 35, 30, 20, 15;
  - any higher channel resets to 0;
  - if NUM_CH<4, only the first NUM_CH of these values apply.
- Coefficient writes are accepted only in IDLE with coef_wr_idx<NUM_CH. The new value is used by any transaction accepted on a later edge.
  - A write attempted in ACCUM or DONE is dropped and pulses coef_err for one cycle.
  - A write with idx≥NUM_CH is dropped and pulses coef_err for one cycle.
- When a write and an input acceptance occur on the same edge in IDLE, the write is applied. The accepted transaction uses the pre-write coefficients.
- If OUT_W ≥ the accumulator width, overflow is constant 0.

## Timing
- Reset values:
  - state=IDLE, so in_ready=1 while rst is high;
  - out_valid=0, score=0, overflow=0, coef_err=0;
  - idx=0, accumulator=0;
  - coefficients take their defaults.
- Acceptance at edge k. The NUM_CH products are added on edges k+1..k+NUM_CH. out_valid is high after edge k+NUM_CH, so the latency is NUM_CH cycles.
- With out_ready held high, out_valid lasts 1 cycle. in_ready rises after edge k+NUM_CH+1, and the next acceptance can happen no earlier than edge k+NUM_CH+2.
- in_ready and out_valid are never high in the same cycle. in_ready is high only in IDLE and out_valid only in DONE.
- Asserting rst mid-ACCUM or mid-DONE returns immediately to the reset values. The in-flight result is discarded and the coefficients revert to their defaults.
- in_data is sampled only on the accept edge. It may change freely afterwards.

## Structure
- Package score_pkg holds:
  - the state enum typedef (IDLE, ACCUM, DONE);
  - the default coefficient localparams DEF_COEF_0..3 = 35, 30, 20, 15;
  - a function returning the default coefficient for index i.
- Sub-module score_coef_regs: the NUM_CH×COEF_W register file with reset defaults, write port, write-enable gating from the FSM, and coef_err generation. It has an asynchronous read port indexed by idx.
- The top level holds the FSM, sample register, shared multiplier, accumulator, saturation logic and output registers.

## Test plan
- Defaults: in_data = {45, 4096, 200, 1000} (channel 3 down to 0) → after 4 cycles, out_valid=1, score=123595, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles → score stays 123595 and out_valid stays 1. Also check that in_ready=0 and a new in_valid is not accepted.
- Coefficient write: in IDLE, write idx 2 with 0, then run the same vector → score=41675. A write during ACCUM → coef_err pulse for 1 cycle, and the coefficient is unchanged.
- Saturation, with OUT_W=20: all coefficients set to 255 and all channels set to 65535 → score=1048575, overflow=1.
- Reset mid-ACCUM: assert rst at edge k+2 → out_valid=0, score=0, coef[2] back to 20. The next transaction is computed correctly.
- NUM_CH=1 build: in_data=7 → score=245 one cycle after acceptance. A write with idx=1 → coef_err.
